// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-byte holding register for gapless back-to-back frames.
module uart_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 22274
) (
    input  logic       clk,
    input  logic       i_reset,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             accept_c, last_c, load_c;

    // Next-state, counters, holding register and registered-output values.
    always_comb begin
        accept_c = i_valid && ready_q;
        last_c   = (cnt_q == LAST_CNT);
        load_c   = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (hold_full_q) begin
                    load_c  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
                if (last_c) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
                if (last_c) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
                if (last_c) begin
                    // Chain straight into the next start bit when a byte is waiting.
                    if (hold_full_q) begin
                        load_c  = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        shift_d = load_c ? hold_q : shift_q;
        hold_d  = accept_c ? i_data : hold_q;

        // Set wins over clear, even though both cannot occur together.
        if (accept_c) begin
            hold_full_d = 1'b1;
        end else if (load_c) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_d];
            default: tx_d = 1'b1;
        endcase

        ready_d = !hold_full_d;
        busy_d  = (state_d != IDLE) || hold_full_d;
    end

    // State and output registers; reset drives the line high immediately.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign o_tx    = tx_q;
    assign o_ready = ready_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomised bench comparing the UART line against a queue-based frame model.
module tb_uart_transmitter;

    localparam int unsigned CPB = 4;

    logic       clk;
    logic       i_reset;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       o_tx;
    logic       o_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Model: expected line level per cycle, plus the holding slot.
    logic       m_line[$];
    logic       m_hold_full;
    logic [7:0] m_hold;
    logic       m_acc;

    uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_tx    (o_tx),
        .o_busy  (o_busy)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_line.delete();
        m_hold_full = 1'b0;
        m_acc       = 1'b0;
    endtask

    // Whole 8N1 frame for one byte, one entry per clock cycle.
    task automatic push_frame(input logic [7:0] b);
        for (int c = 0; c < CPB; c++) m_line.push_back(1'b0);
        for (int k = 0; k < 8; k++)
            for (int c = 0; c < CPB; c++) m_line.push_back(b[k]);
        for (int c = 0; c < CPB; c++) m_line.push_back(1'b1);
    endtask

    // Advance the model across one rising edge using the inputs present at that edge.
    task automatic model_edge();
        logic acc;
        if (i_reset) begin
            model_reset();
            return;
        end
        acc = i_valid && !m_hold_full;
        if (m_line.size() > 0) void'(m_line.pop_front());
        if (m_hold_full && m_line.size() == 0) begin
            push_frame(m_hold);
            m_hold_full = 1'b0;
        end
        if (acc) begin
            m_hold      = i_data;
            m_hold_full = 1'b1;
        end
        m_acc = acc;
    endtask

    task automatic compare_outputs(input string phase);
        logic exp_tx;
        exp_tx = (m_line.size() > 0) ? m_line[0] : 1'b1;
        check({phase, ".tx"}, 32'(o_tx), 32'(exp_tx));
        check({phase, ".ready"}, 32'(o_ready), 32'(!m_hold_full));
        check({phase, ".busy"}, 32'(o_busy), 32'((m_line.size() > 0) || m_hold_full));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step(input string phase);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs(phase);
    endtask

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_data  = 8'h00;
        m_hold  = 8'h00;
        model_reset();

        #2;
        check("reset.tx", 32'(o_tx), 32'd1);
        check("reset.ready", 32'(o_ready), 32'd1);
        check("reset.busy", 32'(o_busy), 32'd0);
        step("reset");
        step("reset");
        i_reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 50; i++) step("idle");

        // Single-cycle valid with 0xA5.
        i_data  = 8'hA5;
        i_valid = 1'b1;
        step("a5");
        i_valid = 1'b0;
        i_data  = 8'h5A;
        for (int i = 0; i < 50; i++) step("a5");

        // 0x00 then 0xFF with valid held high.
        i_data  = 8'h00;
        i_valid = 1'b1;
        for (int i = 0; i < 120 && i_valid; i++) begin
            step("b2b");
            if (m_acc) begin
                if (i_data == 8'h00) i_data = 8'hFF;
                else i_valid = 1'b0;
            end
        end
        if (i_valid) check("b2b.accept_timeout", 32'd1, 32'd0);
        i_valid = 1'b0;
        for (int i = 0; i < 90; i++) step("b2b");

        // Random valid and constantly changing data.
        for (int i = 0; i < 700; i++) begin
            i_valid = 1'($urandom_range(0, 2) == 0);
            i_data  = 8'($urandom);
            step("rand");
        end
        i_valid = 1'b0;
        for (int i = 0; i < 100; i++) step("drain");

        // Reset asserted between edges in the middle of the data bits.
        i_data  = 8'($urandom);
        i_valid = 1'b1;
        step("mid");
        i_valid = 1'b0;
        for (int i = 0; i < 12; i++) step("mid");
        @(posedge clk);
        model_edge();
        #2 i_reset = 1'b1;
        #1;
        check("async_rst.tx", 32'(o_tx), 32'd1);
        check("async_rst.ready", 32'(o_ready), 32'd1);
        check("async_rst.busy", 32'(o_busy), 32'd0);
        model_reset();
        @(negedge clk);
        compare_outputs("in_rst");
        step("in_rst");
        step("in_rst");
        i_reset = 1'b0;
        for (int i = 0; i < 5; i++) step("post_rst");

        // Clean frame after reset.
        i_data  = 8'h3C;
        i_valid = 1'b1;
        step("3c");
        i_valid = 1'b0;
        for (int i = 0; i < 50; i++) step("3c");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serialises bytes onto a UART line as 8N1: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It is the transmit partner of the UART receiver in the same design. It sits between a byte producer (valid/ready handshake) and the board TX pin, and drives the receiver directly in loopback tests. A one-byte holding register lets the producer queue the next byte during a frame, so back-to-back frames have no idle gap.

Parameters:
- CLKS_PER_BIT, 22274, clock cycles per serial bit. Legal range 2..65535; the counter is 16 bits.

Ports:
- clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_data  input  8  byte to send; i_data[0] is sent first.
- i_valid  input  1  producer offers i_data this cycle.
- o_ready  output  1  holding register empty; a byte is accepted on a clock edge where i_valid && o_ready.
- o_tx  output  1  serial line; idles high.
- o_busy  output  1  a frame is in progress, or a byte is held.

Behaviour:
- Reset (asynchronous assert, all flops):
  - o_tx=1, o_ready=1, o_busy=0.
  - State=IDLE, bit counter=0, cycle counter=0, holding register empty.
- All outputs are registered; there are no combinational paths from input to output.
- Handshake:
  - Accept when i_valid && o_ready at a rising edge; i_data is captured into the holding register.
  - The next cycle, o_ready=0 until the shifter consumes the byte.
  - Once o_ready=1, it stays 1 until an accept occurs.
  - i_valid while o_ready=0 is ignored; the producer holds the byte.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - o_tx=1.
  - If the holding register is full, move the byte into the shifter, clear holding (o_ready=1 next cycle), go to START.
  - An accept in cycle N gives o_tx=0 starting at cycle N+2: one cycle to hold, one cycle to launch.
- START: o_tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - o_tx = shifter[bit], each bit for exactly CLKS_PER_BIT cycles.
  - After bit 7, go to STOP.
  - The bit index is 3 bits wide; no wrap beyond 7.
- STOP:
  - o_tx=1 for CLKS_PER_BIT cycles.
  - On the last cycle, if the holding register is full, load the shifter, clear holding, and go directly to START. The next frame's start bit follows with zero gap.
  - Otherwise go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles, from first start-bit cycle to last stop-bit cycle.
- Cycle counter: counts 0..CLKS_PER_BIT-1, resets to 0 on every bit boundary, never free-runs in IDLE.
- Simultaneous accept and shifter load in the same cycle: not possible, because accept requires holding empty and load requires holding full. The flag logic must still be written as set-wins-over-clear for robustness.
- o_busy = (state != IDLE) || holding full. It deasserts the cycle after STOP ends with holding empty.
- Reset mid-frame: the line returns high immediately (asynchronously) and the held byte is discarded. The truncated frame is the receiver's problem; no recovery frame is sent.
- i_data may change freely when no accept occurs; the shifter is unaffected by i_data after load.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset then idle 50 cycles -> o_tx=1, o_ready=1, o_busy=0 throughout.
- Send 0xA5 with a single-cycle valid at cycle N -> o_tx low from N+2 for 4 cycles; then bits 1,0,1,0,0,1,0,1 at 4 cycles each; then high 4 cycles. o_busy falls after 40 frame cycles.
- Offer 0x00 then 0xFF back-to-back with i_valid held high -> second accept the cycle after the first load. The 0xFF start bit immediately follows the first stop bit with no idle cycle; total 80 cycles of frames.
- i_valid high while o_ready=0 with a changing i_data -> only bytes sampled at accept edges appear on o_tx; no duplicates, no drops.
- Assert i_reset asynchronously mid-DATA, between clock edges -> o_tx=1 before the next edge. After release, a new 0x3C sends a clean frame.
- Loopback into the UART receiver at CLKS_PER_BIT=22274, sending 0x55 and 0x81 -> the receiver presents 0x55 and 0x81 with o_ready_to_read pulses.
